// File: rtl/bloom_hash_pkg.sv
// Shared types and constant helpers for the Bloom-filter hash engine.
package bloom_hash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned STAT_W = 16;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned seed_of(input int unsigned k,
                                            input int unsigned base,
                                            input int unsigned stride);
        return base + k * stride;
    endfunction

endpackage

// File: rtl/bloom_hash_step.sv
// One XOR-multiply fold: next = ((acc ^ chunk) * MULT) mod 2^HASH_W, or pass-through when disabled.
module bloom_hash_step #(
    parameter int unsigned CHUNK_W = 5,
    parameter int unsigned HASH_W  = 8,
    parameter int unsigned MULT    = 17
) (
    input  logic [HASH_W-1:0]  acc_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    input  logic               en_i,
    output logic [HASH_W-1:0]  acc_o
);

    localparam logic [HASH_W-1:0] MULT_T = HASH_W'(MULT);

    logic [HASH_W-1:0] chunk_x;
    logic [HASH_W-1:0] mixed;

    if (CHUNK_W >= HASH_W) begin : g_trunc
        assign chunk_x = chunk_i[HASH_W-1:0];
    end else begin : g_zext
        assign chunk_x = {{(HASH_W-CHUNK_W){1'b0}}, chunk_i};
    end

    assign mixed = acc_i ^ chunk_x;
    assign acc_o = en_i ? mixed * MULT_T : acc_i;

endmodule

// File: rtl/bloom_hash_engine.sv
// Multi-cycle XOR-multiply hash engine producing NUM_HASH seeded hashes per input word.
// Optional handshake statistics counter enabled by defining BLOOM_HASH_STATS_EN.
module bloom_hash_engine
    import bloom_hash_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CHUNK_W        = 5,
    parameter int unsigned HASH_W         = 8,
    parameter int unsigned NUM_HASH       = 2,
    parameter int unsigned CHUNKS_PER_CYC = 1,
    parameter int unsigned SEED_BASE      = 31,
    parameter int unsigned SEED_STRIDE    = 2,
    parameter int unsigned MULT           = 17
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_HASH*HASH_W-1:0] out_hash_o,
    output logic                       busy_o
`ifdef BLOOM_HASH_STATS_EN
    ,
    output logic [STAT_W-1:0]          stat_count_o,
    output logic                       stat_sat_o
`endif
);

    localparam int unsigned NUM_CHUNKS = ceil_div(DATA_W, CHUNK_W);
    localparam int unsigned NUM_STEPS  = ceil_div(NUM_CHUNKS, CHUNKS_PER_CYC);
    localparam int unsigned CNT_W      = $clog2(NUM_STEPS + 1);
    localparam int unsigned PAD_W      = NUM_CHUNKS * CHUNK_W;

    state_e state_q, state_d;

    logic               load;
    logic               step;
    logic [PAD_W-1:0]   data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HASH_W-1:0]  acc_q [NUM_HASH];

    logic [CHUNK_W-1:0] chunk [CHUNKS_PER_CYC];
    logic               chunk_en [CHUNKS_PER_CYC];
    logic [HASH_W-1:0]  link [NUM_HASH][CHUNKS_PER_CYC+1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                step   = 1'b1;
                if (cnt_q == CNT_W'(NUM_STEPS - 1)) state_d = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
            for (int unsigned k = 0; k < NUM_HASH; k++) acc_q[k] <= '0;
        end else if (load) begin
            data_q <= PAD_W'(in_data_i);
            cnt_q  <= '0;
            for (int unsigned k = 0; k < NUM_HASH; k++)
                acc_q[k] <= HASH_W'(seed_of(k, SEED_BASE, SEED_STRIDE));
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            for (int unsigned k = 0; k < NUM_HASH; k++) acc_q[k] <= link[k][CHUNKS_PER_CYC];
        end
    end

    // Slots past the last real chunk pass the accumulator through unchanged.
    for (genvar c = 0; c < CHUNKS_PER_CYC; c++) begin : g_slot
        logic [31:0] idx;
        assign idx         = 32'(cnt_q) * CHUNKS_PER_CYC + 32'(c);
        assign chunk[c]    = CHUNK_W'(data_q >> (idx * CHUNK_W));
        assign chunk_en[c] = (idx < NUM_CHUNKS);
    end

    for (genvar k = 0; k < NUM_HASH; k++) begin : g_hash
        assign link[k][0] = acc_q[k];
        for (genvar c = 0; c < CHUNKS_PER_CYC; c++) begin : g_chain
            bloom_hash_step #(
                .CHUNK_W (CHUNK_W),
                .HASH_W  (HASH_W),
                .MULT    (MULT)
            ) u_step (
                .acc_i   (link[k][c]),
                .chunk_i (chunk[c]),
                .en_i    (chunk_en[c]),
                .acc_o   (link[k][c+1])
            );
        end
        assign out_hash_o[k*HASH_W +: HASH_W] = acc_q[k];
    end

`ifdef BLOOM_HASH_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stat_q <= '0;
        else if (out_valid_o && out_ready_i && (stat_q != '1))
            stat_q <= stat_q + 1'b1;
    end

    assign stat_count_o = stat_q;
    assign stat_sat_o   = &stat_q;
`endif

endmodule

// File: tb/tb_bloom_hash_engine.sv
// Directed-vector bench driving three engine configurations side by side.
module tb_bloom_hash_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [31:0] in_data   [3];
    logic        in_ready  [3];
    logic        ov        [3];
    logic        busy      [3];
    logic [15:0] hv        [3];
    logic [7:0]  hash_a;
    logic [15:0] hash_b;
    logic [15:0] hash_c;
    int          total = 0;
    int          bad = 0;
    int          n_hs_a = 0;

`ifdef BLOOM_HASH_STATS_EN
    logic [15:0] stat_cnt [3];
    logic        stat_sat [3];
`endif

    always #5 clk = ~clk;

    assign hv[0] = {8'h00, hash_a};
    assign hv[1] = hash_b;
    assign hv[2] = hash_c;

    // A: 10-bit key, single hash
    bloom_hash_engine #(
        .DATA_W(10), .CHUNK_W(5), .HASH_W(8), .NUM_HASH(1), .CHUNKS_PER_CYC(1),
        .SEED_BASE(31), .SEED_STRIDE(2), .MULT(17)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_i(in_data[0][9:0]), .out_valid_o(ov[0]), .out_ready_i(out_ready[0]),
        .out_hash_o(hash_a), .busy_o(busy[0])
`ifdef BLOOM_HASH_STATS_EN
        , .stat_count_o(stat_cnt[0]), .stat_sat_o(stat_sat[0])
`endif
    );

    // B: default configuration
    bloom_hash_engine #(
        .DATA_W(32), .CHUNK_W(5), .HASH_W(8), .NUM_HASH(2), .CHUNKS_PER_CYC(1)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_i(in_data[1]), .out_valid_o(ov[1]), .out_ready_i(out_ready[1]),
        .out_hash_o(hash_b), .busy_o(busy[1])
`ifdef BLOOM_HASH_STATS_EN
        , .stat_count_o(stat_cnt[1]), .stat_sat_o(stat_sat[1])
`endif
    );

    // C: three chunks per cycle
    bloom_hash_engine #(
        .DATA_W(32), .CHUNK_W(5), .HASH_W(8), .NUM_HASH(2), .CHUNKS_PER_CYC(3)
    ) u_c (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .in_data_i(in_data[2]), .out_valid_o(ov[2]), .out_ready_i(out_ready[2]),
        .out_hash_o(hash_c), .busy_o(busy[2])
`ifdef BLOOM_HASH_STATS_EN
        , .stat_count_o(stat_cnt[2]), .stat_sat_o(stat_sat[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 5-bit chunks, 8-bit hashes, seeds 31+2k, multiplier 17.
    function automatic logic [15:0] model(input logic [31:0] data, input int dw, input int nh);
        logic [15:0] r;
        logic [7:0]  h;
        logic [4:0]  c;
        int          nc;
        r  = '0;
        nc = (dw + 4) / 5;
        for (int k = 0; k < nh; k++) begin
            h = 8'(31 + 2 * k);
            for (int j = 0; j < nc; j++) begin
                c = '0;
                for (int b = 0; b < 5; b++)
                    if (j * 5 + b < dw) c[b] = data[j * 5 + b];
                h = 8'((h ^ {3'b000, c}) * 8'd17);
            end
            r[k*8 +: 8] = h;
        end
        return r;
    endfunction

    task automatic transact(input int d, input logic [31:0] data, input int lat,
                            input logic [15:0] exp, input string tag);
        int n;
        in_data[d]  = data;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        n = 0;
        while (!ov[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_hash"}, {16'h0, hv[d]}, {16'h0, exp});
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        if (d == 0) n_hs_a++;
        check({tag, "_vld_drop"}, {31'h0, ov[d]}, 32'd0);
        check({tag, "_rdy_back"}, {31'h0, in_ready[d]}, 32'd1);
    endtask

    initial begin
        logic [31:0] keys [4];
        keys[0] = 32'hFFFF_FFFF;
        keys[1] = 32'hDEAD_BEEF;
        keys[2] = 32'h1234_5678;
        keys[3] = 32'h8000_0001;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
        end

        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", {31'h0, in_ready[i]}, 32'd1);
            check("rst_out_valid", {31'h0, ov[i]}, 32'd0);
            check("rst_busy", {31'h0, busy[i]}, 32'd0);
            check("rst_hash", {16'h0, hv[i]}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Default config, zero key: seeds 31/33 through seven *17 folds.
        transact(1, 32'h0, 7, 16'h91AF, "b_zero");
        for (int i = 0; i < 4; i++) transact(1, keys[i], 7, model(keys[i], 32, 2), "b_key");

        // Reset two cycles into RUN.
        in_data[1] = 32'hCAFE_F00D; in_valid[1] = 1'b1;
        @(posedge clk); #1; in_valid[1] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("midrun_busy", {31'h0, busy[1]}, 32'd1);
        rst_n = 1'b0; #1;
        check("midrun_in_ready", {31'h0, in_ready[1]}, 32'd1);
        check("midrun_out_valid", {31'h0, ov[1]}, 32'd0);
        check("midrun_busy_clr", {31'h0, busy[1]}, 32'd0);
        check("midrun_hash", {16'h0, hv[1]}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        transact(1, 32'h0, 7, 16'h91AF, "b_after_rst");

        // 10-bit config, hand-folded values.
        transact(0, 32'h000, 2, 16'h00FF, "a_zero");
        transact(0, 32'h3FF, 2, 16'h000F, "a_ones");
        transact(0, 32'h01F, 2, 16'h0000, "a_01f");

        // Hold the result with out_ready low; new in_valid must be ignored.
        in_data[0] = 32'h021; in_valid[0] = 1'b1;
        @(posedge clk); #1; in_valid[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        in_data[0] = 32'h3FF; in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'h0, ov[0]}, 32'd1);
            check("hold_hash", {16'h0, hv[0]}, 32'h00EF);
            check("hold_in_ready", {31'h0, in_ready[0]}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        n_hs_a++;
        check("hold_release", {31'h0, ov[0]}, 32'd0);
        check("hold_idle_busy", {31'h0, busy[0]}, 32'd0);

        // Three chunks per cycle: same hashes, shorter latency.
        transact(2, 32'h0, 3, 16'h91AF, "c_zero");
        for (int i = 0; i < 4; i++) transact(2, keys[i], 3, model(keys[i], 32, 2), "c_key");

`ifdef BLOOM_HASH_STATS_EN
        check("stat_count_a", {16'h0, stat_cnt[0]}, n_hs_a);
        check("stat_sat_a", {31'h0, stat_sat[0]}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
